// File: rtl/xor_share_arbiter_if.sv
// Bus bundle for xor_share_arbiter: request/grant, two word streams and the
// result channel.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer happens
// on a rising clock edge where both valid and ready are high. The sender holds
// data stable while valid is high. Ready never depends on valid in the same
// cycle. A result stays valid and stable until it is taken.
interface xor_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req;
    logic [1:0]       grant;
    logic [WIDTH-1:0] in0_data;
    logic             in0_valid;
    logic             in0_last;
    logic             in0_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_last;
    logic             in1_ready;
    logic [WIDTH-1:0] res_data;
    logic [7:0]       res_len;
    logic             res_id;
    logic             res_valid;
    logic             res_ready;

    // Arbiter side
    modport slave (
        input  req,
        input  in0_data, in0_valid, in0_last,
        input  in1_data, in1_valid, in1_last,
        input  res_ready,
        output grant, in0_ready, in1_ready,
        output res_data, res_len, res_id, res_valid
    );

    // Requester/consumer side
    modport master (
        output req,
        output in0_data, in0_valid, in0_last,
        output in1_data, in1_valid, in1_last,
        output res_ready,
        input  grant, in0_ready, in1_ready,
        input  res_data, res_len, res_id, res_valid
    );
endinterface

// File: rtl/xor_share_arbiter.sv
// Round-robin owner of a single XOR accumulator shared by two frame streams.
// A granted requester streams words. The block folds each word into a running
// XOR, counts the words with saturation at 255, and presents checksum, length
// and owner on the result channel.
module xor_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    xor_share_arbiter_if.slave  bus,
    output logic [1:0]          o_state
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_grant;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ptr;
    logic [WIDTH-1:0] r_res_data;
    logic [7:0]       r_res_len;
    logic             r_res_id;

    logic             w_pick;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic             w_sel_ready;
    logic             w_beat;
    logic [7:0]       w_cnt_inc;

    // Mux the granted stream onto one set of beat signals; the other port is ignored.
    always_comb begin
        w_sel_data  = r_grant[1] ? bus.in1_data  : bus.in0_data;
        w_sel_valid = r_grant[1] ? bus.in1_valid : bus.in0_valid;
        w_sel_last  = r_grant[1] ? bus.in1_last  : bus.in0_last;
        w_sel_ready = (r_state == ST_BUSY) && (r_grant != 2'b00);
        w_beat      = w_sel_valid && w_sel_ready;
        w_cnt_inc   = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    end

    // Next-state and arbitration choice; both requests resolve via the pointer.
    always_comb begin
        w_next = r_state;
        w_pick = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    w_next = ST_BUSY;
                    w_pick = (bus.req == 2'b11) ? r_ptr : bus.req[1];
                end
            end
            ST_BUSY: begin
                if (w_beat && w_sel_last) w_next = ST_RESULT;
            end
            ST_RESULT: begin
                if (bus.res_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register plus accumulator, count, result and pointer updates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'b00;
            r_acc      <= '0;
            r_cnt      <= 8'd0;
            r_ptr      <= 1'b0;
            r_res_data <= '0;
            r_res_len  <= 8'd0;
            r_res_id   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_BUSY) begin
                        r_grant <= w_pick ? 2'b10 : 2'b01;
                        r_acc   <= '0;
                        r_cnt   <= 8'd0;
                    end
                end
                ST_BUSY: begin
                    if (w_beat) begin
                        r_acc <= r_acc ^ w_sel_data;
                        r_cnt <= w_cnt_inc;
                        if (w_sel_last) begin
                            r_res_data <= r_acc ^ w_sel_data;
                            r_res_len  <= w_cnt_inc;
                            r_res_id   <= r_grant[1];
                            r_grant    <= 2'b00;
                        end
                    end
                end
                ST_RESULT: begin
                    // Hand preference to the requester that was not just served.
                    if (bus.res_ready) r_ptr <= ~r_res_id;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.in0_ready = (r_state == ST_BUSY) && r_grant[0];
    assign bus.in1_ready = (r_state == ST_BUSY) && r_grant[1];
    assign bus.res_data  = r_res_data;
    assign bus.res_len   = r_res_len;
    assign bus.res_id    = r_res_id;
    assign bus.res_valid = (r_state == ST_RESULT);
    assign o_state       = r_state;
endmodule

// File: tb/tb_xor_share_arbiter.sv
// Self-checking bench for xor_share_arbiter: table of directed frames,
// hand-written contention / saturation / reset sequences, then random frames
// checked against a frame-level reference model.
module tb_xor_share_arbiter;
    localparam int W = 8;
    typedef logic [W-1:0] word_q_t[$];

    typedef struct {
        int         id;
        int         n;
        logic [7:0] w[4];
        int         gap;
        int         hold;
        logic [7:0] exp_data;
        logic [7:0] exp_len;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         failures = 0;
    int         model_ptr = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_len_q[$];

    xor_share_arbiter_if #(.WIDTH(W)) bus();

    xor_share_arbiter #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_port(input int id, input logic v, input logic [W-1:0] d, input logic l);
        if (id == 0) begin
            bus.in0_valid = v; bus.in0_data = d; bus.in0_last = l;
        end else begin
            bus.in1_valid = v; bus.in1_data = d; bus.in1_last = l;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 2'b00;
        bus.res_ready = 1'b0;
        drive_port(0, 1'b0, '0, 1'b0);
        drive_port(1, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"},     bus.grant,     0);
        check({tag, "_in0_ready"}, bus.in0_ready, 0);
        check({tag, "_in1_ready"}, bus.in1_ready, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_data"},  bus.res_data,  0);
        check({tag, "_res_len"},   bus.res_len,   0);
        check({tag, "_res_id"},    bus.res_id,    0);
        check({tag, "_state"},     dbg_state,     0);
    endtask

    // Caller sets bus.req on a negedge with the DUT in IDLE, then calls this.
    task automatic do_frame(input int id, input word_q_t words, input int gap, input int hold,
                            input logic drop_req, input logic noise,
                            input logic [7:0] exp_data, input logic [7:0] exp_len);
        int lat;
        int other;
        int n;
        other = 1 - id;
        n = words.size();
        lat = 0;
        while (bus.grant == 2'b00 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("grant_latency", lat, 1);
        check("grant_owner", bus.grant, (id == 0) ? 2'b01 : 2'b10);
        if (bus.grant == 2'b00) return;
        check("granted_ready", (id == 0) ? bus.in0_ready : bus.in1_ready, 1);
        if (drop_req) bus.req = 2'b00;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    drive_port(id, 1'b0, W'($urandom), 1'b1);
                    if (noise) drive_port(other, 1'b1, W'($urandom), 1'($urandom_range(0, 1)));
                    check("other_ready_gap", (id == 0) ? bus.in1_ready : bus.in0_ready, 0);
                    @(negedge clk);
                end
            end
            drive_port(id, 1'b1, words[k], (k == n - 1));
            if (noise) drive_port(other, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
            check("other_ready", (id == 0) ? bus.in1_ready : bus.in0_ready, 0);
            @(negedge clk);
        end
        drive_port(0, 1'b0, '0, 1'b0);
        drive_port(1, 1'b0, '0, 1'b0);
        for (int h = 0; h <= hold; h++) begin
            check("res_valid", bus.res_valid, 1);
            check("res_data", bus.res_data, exp_data);
            check("res_len", bus.res_len, exp_len);
            check("res_id", bus.res_id, id);
            check("grant_in_result", bus.grant, 0);
            check("ready_in_result", {bus.in1_ready, bus.in0_ready}, 0);
            if (h == hold) bus.res_ready = 1'b1;
            @(negedge clk);
        end
        bus.res_ready = 1'b0;
        check("res_valid_after_take", bus.res_valid, 0);
        model_ptr = 1 - id;
    endtask

    // Reference model: a frame's checksum is the XOR of all its words and its
    // length is the word count clipped at 255.
    function automatic logic [W-1:0] model_xor(input word_q_t words);
        logic [W-1:0] x = '0;
        foreach (words[k]) x = x ^ words[k];
        return x;
    endfunction

    function automatic logic [7:0] model_len(input word_q_t words);
        return (words.size() > 255) ? 8'd255 : 8'(words.size());
    endfunction

    initial begin
        vec_t    vecs[4];
        word_q_t wq;

        vecs[0] = '{id: 0, n: 3, w: '{8'h3C, 8'hA5, 8'h0F, 8'h00}, gap: 0, hold: 0, exp_data: 8'h96, exp_len: 8'd3};
        vecs[1] = '{id: 1, n: 3, w: '{8'hFF, 8'hFF, 8'h01, 8'h00}, gap: 2, hold: 3, exp_data: 8'h01, exp_len: 8'd3};
        vecs[2] = '{id: 0, n: 1, w: '{8'h5A, 8'h00, 8'h00, 8'h00}, gap: 0, hold: 1, exp_data: 8'h5A, exp_len: 8'd1};
        vecs[3] = '{id: 1, n: 4, w: '{8'h80, 8'h01, 8'h02, 8'h04}, gap: 1, hold: 0, exp_data: 8'h87, exp_len: 8'd4};

        do_reset();
        check_reset_values("reset");

        // Directed frames from the table
        for (int v = 0; v < 4; v++) begin
            wq.delete();
            for (int k = 0; k < vecs[v].n; k++) wq.push_back(vecs[v].w[k]);
            bus.req = (vecs[v].id == 0) ? 2'b01 : 2'b10;
            do_frame(vecs[v].id, wq, vecs[v].gap, vecs[v].hold, 1'b1, 1'b1,
                     vecs[v].exp_data, vecs[v].exp_len);
        end

        // Contention from reset: both requests held, grants alternate 0,1,0
        do_reset();
        bus.req = 2'b11;
        wq = '{8'h11};
        do_frame(0, wq, 0, 0, 1'b0, 1'b0, 8'h11, 8'd1);
        wq = '{8'h22};
        do_frame(1, wq, 0, 0, 1'b0, 1'b0, 8'h22, 8'd1);
        wq = '{8'h11};
        do_frame(0, wq, 0, 0, 1'b1, 1'b0, 8'h11, 8'd1);

        // Length saturation: 300 words of 0x01
        wq.delete();
        for (int k = 0; k < 300; k++) wq.push_back(8'h01);
        bus.req = 2'b01;
        do_frame(0, wq, 0, 0, 1'b1, 1'b0, 8'h00, 8'd255);

        // Mid-frame reset after two beats; pointer currently prefers requester 1
        bus.req = 2'b01;
        @(negedge clk);
        check("mfr_grant", bus.grant, 2'b01);
        bus.req = 2'b00;
        drive_port(0, 1'b1, 8'h12, 1'b0);
        @(negedge clk);
        drive_port(0, 1'b1, 8'h34, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive_port(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        check_reset_values("mfr");
        bus.req = 2'b11;
        wq = '{8'h5A};
        do_frame(0, wq, 0, 0, 1'b1, 1'b0, 8'h5A, 8'd1);

        // Random frames against the reference model
        for (int t = 0; t < 25; t++) begin
            int r;
            int owner;
            int n;
            r = $urandom_range(1, 3);
            owner = (r == 3) ? model_ptr : ((r == 2) ? 1 : 0);
            n = $urandom_range(1, 6);
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(W'($urandom));
            exp_q.push_back(model_xor(wq));
            exp_len_q.push_back(model_len(wq));
            bus.req = 2'(r);
            do_frame(owner, wq, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b1,
                     exp_q.pop_front(), exp_len_q.pop_front());
        end

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xor_share_arbiter.md
# xor_share_arbiter

Round-robin arbiter and sequencer that shares a single XOR accumulator between two requesters. Each requester streams a frame of words over a valid/ready interface. The block folds every accepted word into a running XOR and returns the frame checksum, word count and owner ID on a result handshake. It sits in front of the XOR datapath, which is a plain combinational `a ^ b` per bit, and turns it into a shared, frame-oriented parity/checksum resource.

## Interface
Parameters:
- `WIDTH`, default 8: data and checksum width in bits.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  2: `req[i]` = requester i has a frame to send.
- `grant`  out  2: one-hot; the requester currently owning the accumulator.
- `in0_data`  in  WIDTH: requester 0 data word.
- `in0_valid`  in  1: requester 0 word valid.
- `in0_last`  in  1: requester 0 word is the final word of the frame.
- `in0_ready`  out  1: block accepts a requester 0 word.
- `in1_data`, `in1_valid`, `in1_last`, `in1_ready`: same as above, for requester 1.
- `res_data`  out  WIDTH: XOR of all words in the completed frame.
- `res_len`  out  8: number of words accepted in the frame, saturating at 255.
- `res_id`  out  1: requester that sent the frame.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.

## Operation
- FSM states are IDLE, BUSY and RESULT. Reset puts the FSM in IDLE.
- Reset values:
  - `grant`=0, `in*_ready`=0, `res_valid`=0, `res_data`=0, `res_len`=0, `res_id`=0.
  - Accumulator = 0, count = 0.
  - Priority pointer = 0, meaning requester 0 is preferred.
- IDLE:
  - If exactly one `req` bit is set, grant that requester.
  - If both are set, grant the requester the pointer prefers.
  - On a grant: set `grant`, clear the accumulator and count, and go to BUSY.
  - If no request is set, stay in IDLE.
- BUSY:
  - `inX_ready` = 1 only for the granted requester. The other requester's ready is always 0.
  - A beat is accepted when `valid & ready` are both high. On a beat: accumulator ^= data, and count increments, saturating at 255.
  - A beat with `last`=1 does the following:
    - Loads `res_data` = accumulator ^ data.
    - Loads `res_len` = saturated count + 1.
    - Loads `res_id` = granted index.
    - Clears `grant` and goes to RESULT.
  - `req` is ignored in BUSY. Deasserting `req` does not end the frame; only `last` does.
  - Data and last from the non-granted port are ignored.
- RESULT:
  - `res_valid` = 1, and `res_*` is held stable until `res_ready` is high.
  - On the `res_valid & res_ready` cycle:
    - The pointer is set to prefer the other requester, i.e. pointer = ~`res_id`.
    - The FSM returns to IDLE.
- Frames are at least one word long. A single-word frame returns that word with `res_len`=1.
- Reset asserted in any state, including mid-frame or while `res_valid` is held, returns the block to reset values on the next edge. The partial frame is discarded.

## Timing
- Grant latency: `req` sampled in IDLE gives `grant` high on the next cycle, and ready is high in that same cycle.
- Minimum frame cost: 1 grant cycle + N beat cycles. `res_valid` rises on the cycle after the last beat.
- A result is consumed on a `res_valid & res_ready` edge. The next grant can appear at the earliest on the cycle after that, so the shortest gap between `res_valid` falling and the next `grant` is one IDLE cycle.
- `inX_ready` is a combinational function of state and grant only. It never depends on `inX_valid`.
- Back-pressure: the requester may drop `valid` between beats at any time. The accumulator holds its value across those gaps.

## Test plan
- Single frame from requester 0:
  - Stimulus: `req`=01, beats 0x3C, 0xA5, 0x0F (last).
  - Required response: `grant`=01 one cycle after `req`. Result `res_data`=0x96, `res_len`=3, `res_id`=0, `res_valid` the cycle after the last beat.
- Contention from reset:
  - Stimulus: `req`=11 held, each requester sending a one-word frame (0x11 from requester 0, 0x22 from requester 1).
  - Required response: requester 0 is served first (0x11, id 0), then requester 1 (0x22, id 1), then requester 0 again. Grants alternate.
- Back-pressure and gaps:
  - Stimulus: requester 1 frame 0xFF, 0xFF, 0x01 (last), with `valid` low for 2 cycles between beats, and `res_ready` held low for 3 cycles.
  - Required response: `res_data`=0x01 and `res_len`=3. `res_valid` and outputs stay stable until `res_ready` is high. `in0_ready` stays 0 throughout.
- Length saturation:
  - Stimulus: 300-word frame of 0x01.
  - Required response: `res_len`=255 and `res_data`=0x00.
- Mid-frame reset:
  - Stimulus: `rst` pulsed after 2 beats of a requester 0 frame.
  - Required response: all outputs at reset values, FSM in IDLE, pointer preferring 0. A subsequent one-word frame 0x5A returns `res_data`=0x5A, `res_len`=1.
